// File: rtl/aes_v2_mix_sequencer.sv
// aes_v2_mix_sequencer: issues each column of an AES state to a MixColumns FU and gathers the results
module aes_v2_mix_sequencer #(
  parameter int NUM_COLS = 4
) (
  input  logic                     g_clk,
  input  logic                     g_resetn,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_enc,
  input  logic [32*NUM_COLS-1:0]   req_state,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [32*NUM_COLS-1:0]   rsp_state,
  output logic                     fu_valid,
  output logic [31:0]              fu_rs1,
  output logic [31:0]              fu_rs2,
  output logic                     fu_enc,
  input  logic                     fu_ready,
  input  logic [31:0]              fu_rd
);
  localparam int W  = 32 * NUM_COLS;
  localparam int CW = NUM_COLS > 1 ? $clog2(NUM_COLS) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [W-1:0]    buf_q, buf_d;
  logic            enc_q, enc_d;
  logic [31:0]     col_word;

  assign col_word  = buf_q[32*col_q +: 32];
  assign req_ready = state_q == IDLE;
  assign fu_valid  = state_q == ISSUE;
  assign rsp_valid = state_q == DONE;
  assign fu_rs1    = fu_valid ? col_word : '0;
  assign fu_rs2    = fu_rs1;
  assign fu_enc    = enc_q;
  assign rsp_state = buf_q;

  // State, column index, in-place operand/result buffer and direction latch
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q <= IDLE;
      col_q   <= '0;
      buf_q   <= '0;
      enc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      buf_q   <= buf_d;
      enc_q   <= enc_d;
    end
  end

  // Next state: accept in IDLE, write back one column per FU handshake, hold result until consumed
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    buf_d   = buf_q;
    enc_d   = enc_q;
    case (state_q)
      IDLE: if (req_valid) begin
        state_d = ISSUE;
        buf_d   = req_state;
        enc_d   = req_enc;
        col_d   = '0;
      end
      ISSUE: if (fu_ready) begin
        buf_d[32*col_q +: 32] = fu_rd;
        if (col_q == CW'(NUM_COLS - 1)) state_d = DONE;
        else col_d = col_q + 1'b1;
      end
      DONE: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: doc/aes_v2_mix_sequencer.md
Name: aes_v2_mix_sequencer

Overview:
- Initiator for the single-column AES MixColumns functional-unit interface (valid/rs1/rs2/enc -> ready/rd).
- Accepts a full 128-bit AES state plus direction, issues one column per FU transaction, collects each rd, and returns the mixed state.
- Sits between the AES round controller and any mix FU variant, single-cycle or multi-cycle.

Parameters:
- NUM_COLS, 4, number of 32-bit columns per state. State width is 32*NUM_COLS. Must be ≥1.

Ports:
- g_clk  input  1  clock, rising edge
- g_resetn  input  1  reset, asynchronous, active-low
- req_valid  input  1  request present
- req_ready  output  1  sequencer can accept a request
- req_enc  input  1  1 = forward MixColumns, 0 = InvMixColumns
- req_state  input  32*NUM_COLS  column c = bits [32c+31:32c]; row r byte = [32c+8r+7:32c+8r]
- rsp_valid  output  1  result present
- rsp_ready  input  1  consumer accepts result
- rsp_state  output  32*NUM_COLS  mixed state, same packing as req_state
- fu_valid  output  1  FU operands valid
- fu_rs1  output  32  current column word
- fu_rs2  output  32  current column word; FU takes bytes 0,1 from rs1[15:0] and bytes 2,3 from rs2[31:16]
- fu_enc  output  1  latched req_enc
- fu_ready  input  1  FU result valid this cycle
- fu_rd  input  32  FU result column

Behaviour:
- Reset (async assert, sync release):
  - FSM = IDLE; column counter = 0; state buffer = 0; enc latch = 0.
  - req_ready=1, rsp_valid=0, fu_valid=0, fu_enc=0; rsp_state, fu_rs1, fu_rs2 = 0.
- One 32*NUM_COLS buffer holds operands and is updated in place. rsp_state = buffer at all times. rsp_state is meaningful only while rsp_valid=1.
- FSM states:
  - IDLE:
    - req_ready=1.
    - On req_valid: capture req_state into the buffer and req_enc into the latch, set col=0, go to ISSUE.
  - ISSUE:
    - req_ready=0; fu_valid=1; fu_rs1=fu_rs2=buffer column col; fu_enc=latch.
    - Operands are held stable until fu_ready=1.
    - On fu_ready=1: write fu_rd into buffer column col. If col==NUM_COLS-1, go to DONE; otherwise col+1 and stay in ISSUE.
    - fu_valid stays asserted across back-to-back columns.
  - DONE:
    - fu_valid=0; rsp_valid=1; buffer frozen.
    - On rsp_ready=1: go to IDLE.
    - req_ready is 0 in DONE, so there is no same-cycle accept. The next request is accepted at the earliest one cycle later.
- Latency with a zero-wait FU (ready=valid):
  - Accept in cycle 0; fu_valid in cycles 1..NUM_COLS; rsp_valid from cycle NUM_COLS+1.
  - Throughput: one state per NUM_COLS+2 cycles when rsp_ready is held high.
- Stalls:
  - Each cycle of fu_ready=0 in ISSUE adds one cycle.
  - rsp_ready=0 holds DONE indefinitely with rsp_state stable.
- fu_ready while fu_valid=0 is ignored. fu_rd is sampled only when fu_valid && fu_ready.
- Request inputs are ignored outside IDLE.
- Counter wrap: col never exceeds NUM_COLS-1 and resets to 0 on each accept.
- Reset mid-operation: fu_valid and rsp_valid drop immediately (asynchronous); the partial result is discarded. The FU must tolerate an abandoned valid.
- No arithmetic is performed locally; all GF(2^8) work is in the FU.

Test Plan:
- Forward, zero-wait FU, NUM_COLS=4:
  - Stimulus: columns {32'h455313db, 32'h5c220af2, 32'hc6c6c6c6, 32'h01010101}, enc=1.
  - Response: rsp_state columns {32'hbca14d8e, 32'h9d58dc9f, 32'hc6c6c6c6, 32'h01010101}; rsp_valid in cycle 5; fu_valid high cycles 1-4.
- Inverse:
  - Stimulus: the previous output state with enc=0.
  - Response: the original columns, fu_enc=0 throughout.
- FU stall:
  - Stimulus: insert 3 wait cycles on column 1 and 1 wait cycle on column 3.
  - Response: fu_rs1/fu_rs2 stable during each stall; same results; rsp_valid in cycle 9.
- Response backpressure:
  - Stimulus: rsp_ready=0 for 5 cycles after rsp_valid, with req_valid held high and a different req_state.
  - Response: rsp_state stable, req_ready=0; second request accepted exactly one cycle after the rsp handshake.
- Reset mid-operation:
  - Stimulus: deassert g_resetn while col=2.
  - Response: fu_valid=0 and rsp_valid=0 immediately; req_ready=1 after release; a fresh request completes correctly.
- Spurious FU signalling:
  - Stimulus: fu_ready=1 with fu_rd=32'hffffffff while in IDLE and DONE.
  - Response: buffer and rsp_state unchanged.
